// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
// Shared constants and helpers for the multi-lane serializer:
//   - TMDS control-period codes (candidates for the underflow idle word)
//   - PRBS7 (x^7 + x^6 + 1) seed, taps and next-state helper
//   - width helper for the per-word bit counter
// No ports (package).
// ---------------------------------------------------------------------------
package ser_pkg;

  // TMDS control codes for {C1,C0} = 00, 01, 10, 11
  localparam logic [9:0] TMDS_CTRL00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL11 = 10'b1010101011;

  // PRBS7 generator: Fibonacci form, output taken from bit 6
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'b1100000;

  // Bits needed to count 0..width-1 (never less than one bit)
  function automatic int countWidth(input int width);
    if (width < 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

  // One PRBS7 step: feedback from the x^7 and x^6 taps shifts in at bit 0
  function automatic logic [6:0] prbs7Next(input logic [6:0] state);
    return {state[5:0], ^(state & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/serializer_lane.sv
// ---------------------------------------------------------------------------
// serializer_lane
// One WIDTH-bit load/shift register feeding a single serial lane.
// Ports:
//   clk       in   bit-rate clock
//   reset     in   synchronous, active-high reset (register cleared)
//   enable    in   1 = load/shift allowed, 0 = register frozen
//   load      in   load loadData this cycle (takes priority over shift)
//   shift     in   move one position toward the output bit
//   loadData  in   WIDTH-bit word to load
//   serialBit out  current output bit (bit 0 if LSB_FIRST, else bit WIDTH-1)
// ---------------------------------------------------------------------------
module serializer_lane
  import ser_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] loadData,
  output logic             serialBit
);

  logic [WIDTH-1:0] shiftReg;
  logic [WIDTH-1:0] shifted;

  // The output bit is a register bit; shifting moves the next bit onto it.
  if (LSB_FIRST != 0) begin : gLsbFirst
    assign shifted   = {1'b0, shiftReg[WIDTH-1:1]};
    assign serialBit = shiftReg[0];
  end else begin : gMsbFirst
    assign shifted   = {shiftReg[WIDTH-2:0], 1'b0};
    assign serialBit = shiftReg[WIDTH-1];
  end

  // Shift register: load has priority, everything frozen when not enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg <= {WIDTH{1'b0}};
    end else if (enable && load) begin
      shiftReg <= loadData;
    end else if (enable && shift) begin
      shiftReg <= shifted;
    end
  end

endmodule

// File: rtl/multi_lane_serializer.sv
// ---------------------------------------------------------------------------
// multi_lane_serializer
// N-lane parallel-to-serial shifter on the bit-rate clock. An internal bit
// counter marks word boundaries; one multi-lane word is accepted per
// valid/ready transfer into a one-deep buffer. When the buffer is empty at a
// boundary every lane sends IDLE_WORD and an underflow is flagged/counted.
// Optional feature macro: SER_PRBS_EN (adds prbsMode, per-lane PRBS7 output).
// Ports:
//   clk            in   bit-rate clock (only clock)
//   reset          in   synchronous, active-high reset
//   enable         in   1 = shifting runs, 0 = counter and shifters frozen
//   prbsMode       in   (SER_PRBS_EN only) 1 = lanes carry PRBS7
//   parallelData   in   LANES*WIDTH, lane k at [k*WIDTH +: WIDTH]
//   dataValid      in   parallelData valid
//   dataReady      out  word accepted this cycle when dataValid is high
//   serialOut      out  LANES serial bits, one per lane
//   wordStrobe     out  pulse while the first bit of a new word is out
//   underflow      out  pulse after IDLE_WORD was loaded
//   underflowCount out  saturating count of underflow pulses
// ---------------------------------------------------------------------------
module multi_lane_serializer
  import ser_pkg::*;
#(
  parameter int               LANES       = 3,
  parameter int               WIDTH       = 10,
  parameter int               LSB_FIRST   = 1,
  parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'(TMDS_CTRL00),
  parameter int               UFLOW_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
`ifdef SER_PRBS_EN
  input  logic                   prbsMode,
`endif
  input  logic [LANES*WIDTH-1:0] parallelData,
  input  logic                   dataValid,
  output logic                   dataReady,
  output logic [LANES-1:0]       serialOut,
  output logic                   wordStrobe,
  output logic                   underflow,
  output logic [UFLOW_CNT_W-1:0] underflowCount
);

  localparam int            CW       = countWidth(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [CW-1:0]          bitCount;
  logic [LANES*WIDTH-1:0] bufData;
  logic                   bufFull;
  logic                   boundary;
  logic                   transfer;
  logic                   dataHold;
  logic                   laneLoad;
  logic                   laneShift;
  logic                   uflowEvent;
  logic [LANES*WIDTH-1:0] loadWord;
  logic [LANES-1:0]       laneBits;

  assign boundary = enable & (bitCount == LAST_BIT);

  // A boundary frees the buffer in the same cycle, so back-to-back words
  // never leave a bubble.
  assign dataReady  = ~dataHold & (~bufFull | boundary);
  assign transfer   = dataValid & dataReady;
  assign laneLoad   = boundary & ~dataHold;
  assign laneShift  = ~boundary & ~dataHold;
  assign uflowEvent = boundary & ~bufFull & ~dataHold;
  assign loadWord   = bufFull ? bufData : {LANES{IDLE_WORD}};

  // Bit counter: wraps at WIDTH-1 while enabled, holds otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      bitCount <= {CW{1'b0}};
    end else if (boundary) begin
      bitCount <= {CW{1'b0}};
    end else if (enable) begin
      bitCount <= bitCount + CW'(1);
    end
  end

  // One-deep holding buffer: a new capture overrides the boundary drain
  always_ff @(posedge clk) begin
    if (reset) begin
      bufData <= {(LANES*WIDTH){1'b0}};
      bufFull <= 1'b0;
    end else if (transfer) begin
      bufData <= parallelData;
      bufFull <= 1'b1;
    end else if (boundary && bufFull && !dataHold) begin
      bufFull <= 1'b0;
    end
  end

  // Word strobe and underflow pulses line up with bitCount == 0
  always_ff @(posedge clk) begin
    if (reset) begin
      wordStrobe <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wordStrobe <= laneLoad;
      underflow  <= uflowEvent;
    end
  end

  // Underflow counter saturates at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      underflowCount <= {UFLOW_CNT_W{1'b0}};
    end else if (uflowEvent && (underflowCount != {UFLOW_CNT_W{1'b1}})) begin
      underflowCount <= underflowCount + UFLOW_CNT_W'(1);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : gLane
    serializer_lane #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
    ) uLane (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .load      (laneLoad),
      .shift     (laneShift),
      .loadData  (loadWord[k*WIDTH +: WIDTH]),
      .serialBit (laneBits[k])
    );
  end

`ifdef SER_PRBS_EN
  logic       prbsModeD;
  logic [6:0] prbsState;
  logic       prbsRise;

  // Data path is parked (buffer held, no loads) while PRBS is selected
  assign dataHold = prbsMode;
  assign prbsRise = prbsMode & ~prbsModeD;

  // Registered mode; the output switches one cycle after prbsMode rises,
  // which is when the freshly seeded generator is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      prbsModeD <= 1'b0;
    end else begin
      prbsModeD <= prbsMode;
    end
  end

  // PRBS7 generator: reseeded on reset and on each prbsMode rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      prbsState <= PRBS7_SEED;
    end else if (prbsRise) begin
      prbsState <= PRBS7_SEED;
    end else if (enable && prbsModeD) begin
      prbsState <= prbs7Next(prbsState);
    end
  end

  assign serialOut = prbsModeD ? {LANES{prbsState[6]}} : laneBits;
`else
  assign dataHold  = 1'b0;
  assign serialOut = laneBits;
`endif

endmodule

// File: tb/tb_multi_lane_serializer.sv
// ---------------------------------------------------------------------------
// tb_multi_lane_serializer
// Self-checking bench: table of directed vectors for the idle/underflow
// behaviour after reset, hand sequences for single transfer, sustained
// streaming, reset mid-word, MSB-first and counter saturation, and a random
// phase compared against a word-level reference model.
// ---------------------------------------------------------------------------
module tb_multi_lane_serializer;

  localparam logic [9:0] IDLE = 10'b1101010100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: default parameters (3 lanes, LSB first)
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [29:0] parallelData = 30'h0;
  logic        dataValid = 1'b0;
  logic        dataReady;
  logic [2:0]  serialOut;
  logic        wordStrobe;
  logic        underflow;
  logic [15:0] underflowCount;
`ifdef SER_PRBS_EN
  logic        prbsMode = 1'b0;
`endif

  multi_lane_serializer dut0 (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
`ifdef SER_PRBS_EN
    .prbsMode       (prbsMode),
`endif
    .parallelData   (parallelData),
    .dataValid      (dataValid),
    .dataReady      (dataReady),
    .serialOut      (serialOut),
    .wordStrobe     (wordStrobe),
    .underflow      (underflow),
    .underflowCount (underflowCount)
  );

  // DUT 1: one lane, MSB first, 2-bit underflow counter
  logic       rst1 = 1'b1;
  logic       en1 = 1'b1;
  logic [9:0] data1 = 10'h0;
  logic       vld1 = 1'b0;
  logic       ready1;
  logic [0:0] ser1;
  logic       strobe1;
  logic       under1;
  logic [1:0] cnt1;
`ifdef SER_PRBS_EN
  logic       prbs1 = 1'b0;
`endif

  multi_lane_serializer #(.LANES(1), .LSB_FIRST(0), .UFLOW_CNT_W(2)) dut1 (
    .clk            (clk),
    .reset          (rst1),
    .enable         (en1),
`ifdef SER_PRBS_EN
    .prbsMode       (prbs1),
`endif
    .parallelData   (data1),
    .dataValid      (vld1),
    .dataReady      (ready1),
    .serialOut      (ser1),
    .wordStrobe     (strobe1),
    .underflow      (under1),
    .underflowCount (cnt1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: current word, bit index within it, buffer state
  int          mCount;
  bit          mBufFull;
  logic [29:0] mBuf;
  logic [29:0] mCur;
  bit          mStrobe;
  bit          mUnder;
  int          mUcnt;

  // Outputs sampled by the last runCycle
  logic [2:0]  sSer;
  logic        sStrobe;
  logic        sUnder;
  logic        sReady;
  logic [15:0] sCnt;

  task automatic modelReset();
    mCount = 0; mBufFull = 0; mBuf = '0; mCur = '0;
    mStrobe = 0; mUnder = 0; mUcnt = 0;
  endtask

  task automatic doReset();
    reset = 1'b1; enable = 1'b1; dataValid = 1'b0; parallelData = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
  endtask

  task automatic runCycle(input bit rst, input bit en, input bit vld, input logic [29:0] data);
    logic [2:0] eSer;
    logic [9:0] lw;
    bit eReady;
    bit xfer;
    reset = rst; enable = en; dataValid = vld; parallelData = data;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      lw = mCur[k*10 +: 10];
      eSer[k] = lw[mCount];
    end
    eReady = !mBufFull || (en && mCount == 9);
    sSer = serialOut; sStrobe = wordStrobe; sUnder = underflow;
    sReady = dataReady; sCnt = underflowCount;
    check("ser/strobe/uflow/count/ready", {sSer, sStrobe, sUnder, sCnt, sReady},
          {eSer, mStrobe, mUnder, 16'(mUcnt), eReady});
    xfer = vld && eReady;
    if (rst) begin
      modelReset();
    end else begin
      if (en) begin
        if (mCount == 9) begin
          mCur = mBufFull ? mBuf : {3{IDLE}};
          mUnder = !mBufFull;
          if (mUnder && mUcnt < 65535) mUcnt++;
          mBufFull = 0;
          mStrobe = 1;
          mCount = 0;
        end else begin
          mCount++;
          mStrobe = 0;
          mUnder = 0;
        end
      end else begin
        mStrobe = 0;
        mUnder = 0;
      end
      if (xfer) begin
        mBuf = data;
        mBufFull = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        en;
    logic        vld;
    logic [29:0] data;
    logic [2:0]  ser;
    logic        strobe;
    logic        under;
    logic [15:0] cnt;
    logic        ready;
  } vec_t;

  vec_t tbl[41];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  idleV;
    logic [9:0]  got;
    logic [29:0] cw;
    logic [29:0] sentQ[$];
    logic [29:0] recvQ[$];
    int          w;
    int          idx;
    bit          collecting;
    int          readyCnt;
    bit          seen;
    int          pulses;
    logic [31:0] r;

    // ---- Directed table: idle words after reset, 4 underflows in 40 cycles
    idleV = IDLE;
    for (int i = 0; i < 41; i++) begin
      tbl[i].en = 1'b1;
      tbl[i].vld = 1'b0;
      tbl[i].data = '0;
      tbl[i].ser = (i < 10) ? 3'b000 : {3{idleV[(i - 10) % 10]}};
      tbl[i].strobe = (i >= 10) && (i % 10 == 0);
      tbl[i].under = (i >= 10) && (i % 10 == 0);
      tbl[i].cnt = 16'(i / 10);
      tbl[i].ready = 1'b1;
    end
    doReset();
    for (int i = 0; i < 41; i++) begin
      enable = tbl[i].en; dataValid = tbl[i].vld; parallelData = tbl[i].data;
      @(negedge clk);
      check("idle table", {serialOut, wordStrobe, underflow, underflowCount, dataReady},
            {tbl[i].ser, tbl[i].strobe, tbl[i].under, tbl[i].cnt, tbl[i].ready});
      @(posedge clk); #1;
    end

    // ---- Single transfer of lane0 = 3A5
    doReset();
    got = '0;
    for (int c = 0; c < 25; c++) begin
      runCycle(0, 1, (c == 2), (c == 2) ? 30'h3A5 : 30'h0);
      if (c >= 10 && c < 20) got[c - 10] = sSer[0];
      if (c == 10) check("single strobe", sStrobe, 1'b1);
    end
    check("single word lane0", got, 10'h3A5);

    // ---- Sustained valid, 100 incrementing words
    doReset();
    w = 0; collecting = 0; idx = 0; readyCnt = 0; cw = '0;
    for (int c = 0; c < 1200 && recvQ.size() < 100; c++) begin
      parallelData = {10'(w * 3 + 2), 10'(w * 3 + 1), 10'(w * 3)};
      runCycle(0, 1, (w < 100), parallelData);
      if (c >= 20 && c < 120 && sReady) readyCnt++;
      if (w < 100 && sReady) begin
        sentQ.push_back(parallelData);
        w++;
      end
      if (sStrobe) begin
        collecting = 1;
        idx = 0;
      end
      if (collecting) begin
        for (int k = 0; k < 3; k++) cw[k*10 + idx] = sSer[k];
        idx++;
        if (idx == 10) begin
          recvQ.push_back(cw);
          collecting = 0;
        end
      end
    end
    check("stream words received", recvQ.size(), 100);
    for (int i = 0; i < 100 && i < recvQ.size() && i < sentQ.size(); i++)
      check("stream word order", recvQ[i], sentQ[i]);
    check("stream no underflow", sCnt, 16'h0);
    check("stream ready once per word", readyCnt, 10);

    // ---- Randomised phase against the reference model
    doReset();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom;
      runCycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
               ($urandom_range(0, 2) != 0), r[29:0]);
    end

    // ---- Reset at bitCount 4 with a full buffer discards the word
    doReset();
    runCycle(0, 1, 1, {10'h3FF, 10'h000, 10'h3FF});
    for (int c = 1; c < 4; c++) runCycle(0, 1, 0, 30'h0);
    runCycle(1, 1, 0, 30'h0);
    check("midreset buffer was full", sReady, 1'b0);
    runCycle(0, 1, 0, 30'h0);
    check("midreset serialOut", sSer, 3'b000);
    check("midreset ready", sReady, 1'b1);
    check("midreset count", sCnt, 16'h0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      runCycle(0, 1, 0, 30'h0);
      if (sSer == 3'b101) seen = 1;
    end
    check("midreset word never sent", seen, 1'b0);

    // ---- MSB-first lane with word 200, then counter saturation
    rst1 = 1'b1; en1 = 1'b1; vld1 = 1'b0; data1 = 10'h0;
    @(posedge clk); #1;
    rst1 = 1'b0; vld1 = 1'b1; data1 = 10'h200;
    got = '0; pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 0) check("msb ready", ready1, 1'b1);
      if (c >= 10 && c < 20) got = {got[8:0], ser1[0]};
      if (c == 10) check("msb strobe", strobe1, 1'b1);
      if (c >= 20 && under1) pulses++;
      @(posedge clk); #1;
      vld1 = 1'b0;
    end
    check("msb word", got, 10'h200);
    check("sat underflow pulses", pulses, 6);
    check("sat underflow count", cnt1, 2'b11);

`ifdef SER_PRBS_EN
    // ---- PRBS7 on every lane, from seed 7F, repeating after 127 bits
    begin
      bit o[260];
      for (int n = 0; n < 7; n++) o[n] = 1'b1;
      for (int n = 7; n < 260; n++) o[n] = o[n - 7] ^ o[n - 6];
      doReset();
      prbsMode = 1'b1; dataValid = 1'b1;
      for (int n = 0; n < 256; n++) begin
        @(negedge clk);
        if (n >= 1) check("prbs bit", serialOut, {3{o[n - 1]}});
        check("prbs ready low", dataReady, 1'b0);
        @(posedge clk); #1;
      end
      prbsMode = 1'b0;
      doReset();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_lane_serializer.md
Name: multi_lane_serializer

Overview:
Parametrised N-lane parallel-to-serial shifter running entirely on the bit-rate clock, with an internal word counter instead of an external load strobe. Accepts one multi-lane word per transfer through a valid/ready handshake into a one-deep holding buffer. Inserts a configurable idle word on underflow and counts underflows. Feeds per-lane differential output buffers in DVI/HDMI and LVDS-panel output paths.

Parameters:
LANES, 3, number of serial lanes
WIDTH, 10, bits per lane word (≥2)
LSB_FIRST, 1, 1 = bit 0 transmitted first, 0 = bit WIDTH-1 first
IDLE_WORD, 10'b1101010100, per-lane word sent on underflow (WIDTH bits, same for all lanes)
UFLOW_CNT_W, 16, underflow counter width

Ports:
clk  in  1  bit-rate clock; the only clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = shifting runs; 0 = counter and shift registers frozen
parallelData  in  LANES*WIDTH  lane k at [k*WIDTH +: WIDTH]
dataValid  in  1  parallelData valid
dataReady  out  1  block accepts parallelData this cycle
serialOut  out  LANES  serial bit per lane, straight from a register
wordStrobe  out  1  one-cycle pulse when the first bit of a new word is on serialOut
underflow  out  1  one-cycle pulse when IDLE_WORD was loaded
underflowCount  out  UFLOW_CNT_W  saturating count of underflow pulses

Behaviour:
- Single clock; reset is synchronous and active-high on clk/reset.
- Reset: bitCount=0, buffer empty, all shift registers 0, serialOut=0, wordStrobe=0, underflow=0, underflowCount=0. Reset mid-word discards the word in flight and the buffered word; no partial word resumes.
- bitCount runs 0..WIDTH-1 and wraps while enable=1. boundary = enable & (bitCount==WIDTH-1).
- On boundary, each lane shift register loads from the buffer if full (buffer then empties), else loads IDLE_WORD and underflow pulses the next cycle. Otherwise, when enabled, registers shift one position toward the output bit.
- serialOut[k] = shiftReg_k[0] if LSB_FIRST, else shiftReg_k[WIDTH-1]. The first bit of a loaded word appears in the cycle with bitCount==0. wordStrobe is high in that same cycle.
- dataReady = !bufFull | boundary. Transfer occurs when dataValid & dataReady.
- Boundary with full buffer and a transfer in the same cycle: the old word goes to the shift register and the new word is captured in the buffer, which stays full (no bubble).
- Latency: a word captured into an empty buffer at edge E is first on the wire after the next boundary edge. Worst case WIDTH cycles; with sustained valid, throughput is 1 word per WIDTH cycles.
- enable=0: bitCount, shift registers and serialOut hold. No underflow. dataReady = !bufFull.
- underflowCount increments on each underflow pulse and saturates at all-ones (no wrap).

Optional Feature:
SER_PRBS_EN:
- Defined: adds input port prbsMode (1 bit).
  - While prbsMode=1, each lane carries PRBS7 (x^7+x^6+1), seeded 7'h7F at reset and on the prbsMode rising edge. Generator advances one bit per enabled cycle.
  - dataReady=0, buffer contents are held, underflow and wordStrobe are suppressed, and bitCount keeps running.
  - On prbsMode falling, data resumes at the next boundary.
- Undefined: no prbsMode port and no PRBS logic; the behaviour above is unchanged.

Decomposition:
- Package ser_pkg:
  - default IDLE_WORD constants (TMDS control codes 00/01/10/11)
  - PRBS7 seed and taps
  - clog2-based bitCount width function
- Sub-module serializer_lane:
  - one WIDTH-bit load/shift register with LSB_FIRST, load, shift and enable inputs
  - instantiated LANES times by a generate loop
  - the top level owns bitCount, the buffer, the handshake and underflow.

Test Plan:
1. Reset, enable=1, dataValid=0 for 40 cycles -> every lane sends 1101010100 per word starting at bit 0 (LSB first: 0,0,1,0,1,0,1,0,1,1), underflow pulses 4 times, underflowCount=4.
2. Single transfer, lane0=10'h3A5, lanes1/2=10'h000 -> after the next boundary serialOut[0]=1,0,1,0,0,1,0,1,1,1, wordStrobe on the first bit, idle words before and after.
3. dataValid held high with an incrementing pattern for 100 words -> no underflow, words in order, dataReady high exactly once per 10 cycles after the buffer fills.
4. LSB_FIRST=0, word 10'h200 -> serialOut[0]=1 then nine 0s.
5. reset asserted at bitCount=4 with a full buffer -> next cycle serialOut=0, dataReady=1, the buffered word is never transmitted, underflowCount=0.
6. SER_PRBS_EN defined, prbsMode=1 for 127 cycles -> each lane emits the 127-bit PRBS7 sequence from seed 7F, then it repeats; dataReady=0 throughout.
